control_fsm: RTL

Multi-cycle control unit for the RV32I datapath. Latches each instruction fetched from instruction memory and steps it through FETCH/DECODE/EXEC/MEM/WB. Drives the datapath control word (RegWrite, ALUsrc, ALUctl, PCsrc, MemtoReg, memory strobes) and consumes the ALUzero/ALUneg flags for branch resolution. Sits directly upstream of `datapath`, which supplies `im_data` and the flags.

---
 rtl/control_fsm.sv | 104 ++++++++++
 1 files changed

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I control unit; define CONTROL_FSM_ILLEGAL_TRAP_EN to halt on unknown opcodes instead of executing a NOP
module control_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] im_data,
  input  logic        ALUzero,
  input  logic        ALUneg,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [1:0]  MemSize,
  output logic        ALUsrc,
  output logic [2:0]  ALUctl,
  output logic [1:0]  PCsrc,
  output logic [2:0]  MemtoReg,
  output logic        halted,
  output logic        illegal
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  localparam state_t UNKNOWN_NXT = HALT;
`else
  localparam state_t UNKNOWN_NXT = WB;
`endif
  state_t state, state_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic bit30, bit20;
  logic op_r, op_i, op_ld, op_st, op_br, op_lui, op_auipc, op_jal, op_jalr, op_ebrk, known;
  logic slt, taken, in_x, wb;
  logic [2:0] alu_fn;
  state_t fetch_nxt;
  logic unused_im;
  assign unused_im = ^{im_data[31], im_data[29:21], im_data[19:15], im_data[11:7]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {opcode, funct3, bit30, bit20} <= '0;
    end else begin
      state <= state_n;
      if (state == FETCH) {opcode, funct3, bit30, bit20} <= {im_data[6:0], im_data[14:12], im_data[30], im_data[20]};
    end
  end
  assign op_r     = opcode == 7'h33;
  assign op_i     = opcode == 7'h13;
  assign op_ld    = opcode == 7'h03;
  assign op_st    = opcode == 7'h23;
  assign op_br    = opcode == 7'h63;
  assign op_lui   = opcode == 7'h37;
  assign op_auipc = opcode == 7'h17;
  assign op_jal   = opcode == 7'h6f;
  assign op_jalr  = opcode == 7'h67;
  assign op_ebrk  = opcode == 7'h73 && bit20;
  assign known    = op_r | op_i | op_ld | op_st | op_br | op_lui | op_auipc | op_jal | op_jalr | op_ebrk;
  // every instruction boundary parks in IDLE when run is low
  assign fetch_nxt = run ? FETCH : IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fetch_nxt;
      FETCH:   state_n = DECODE;
      DECODE:  state_n = op_ebrk ? HALT : known ? EXEC : UNKNOWN_NXT;
      EXEC:    state_n = op_br ? fetch_nxt : (op_ld | op_st) ? MEM : WB;
      MEM:     state_n = op_st ? fetch_nxt : WB;
      WB:      state_n = fetch_nxt;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end
  assign slt    = funct3[2:1] == 2'b01;
  assign alu_fn = funct3 == 3'b000 ? ((op_r & bit30) ? 3'b001 : 3'b000)
                : funct3 == 3'b001 ? 3'b101
                : slt              ? 3'b001
                : funct3 == 3'b100 ? 3'b100
                : funct3 == 3'b101 ? (bit30 ? 3'b111 : 3'b110)
                : funct3 == 3'b110 ? 3'b011 : 3'b010;
  // bltu/bgeu resolve like blt/bge: only the signed flag is available
  assign taken  = (funct3[2] ? ALUneg : ALUzero) ^ funct3[0];
  assign in_x   = state == EXEC || state == MEM || state == WB;
  assign wb     = state == WB;
  assign IRWrite  = state == FETCH;
  assign PCWrite  = (state == EXEC && op_br) || (state == MEM && op_st) || wb;
  assign RegWrite = wb && known;
  assign MemWrite = state == MEM && op_st;
  assign MemSize  = (state == MEM || (wb && op_ld)) ? funct3[1:0] : 2'b00;
  assign ALUsrc   = in_x && (op_i || op_ld || op_st || op_jalr);
  assign ALUctl   = !in_x ? 3'b000 : op_br ? 3'b001 : (op_r | op_i) ? alu_fn : 3'b000;
  assign PCsrc    = ((state == EXEC && op_br && taken) || (wb && op_jal)) ? 2'b01
                  : (wb && op_jalr) ? 2'b10 : 2'b00;
  assign MemtoReg = !(wb && known) ? 3'b000
                  : op_ld    ? 3'b001
                  : op_lui   ? 3'b011
                  : op_auipc ? 3'b100
                  : (op_jal | op_jalr) ? 3'b010
                  : ((op_r | op_i) && slt) ? 3'b101 : 3'b000;
  assign halted = state == HALT;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  assign illegal = halted && !op_ebrk;
`else
  assign illegal = 1'b0;
`endif
endmodule
